// File: rtl/motor_pio_edge_ctl.sv
// Avalon-MM PIO for the stepper-motor subsystem: synchronised inputs with per-bit edge capture, set/clear output register, irq.
// Optional input debounce filter is built when MOTOR_PIO_DEBOUNCE_EN is defined.
module motor_pio_edge_ctl #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_OUT_SET = 3'd5;
    localparam logic [2:0] ADDR_OUT_CLR = 3'd6;

    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_illegal_params
        $error("motor_pio_edge_ctl: parameter out of range");
    end

    if (WIDTH < 32) begin : g_wd_upper
        logic w_unused_wd;
        assign w_unused_wd = ^writedata[31:WIDTH];
    end

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_f_d;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_out_nxt;
    logic [31:0]      w_rd;

    assign w_wr  = chipselect & ~write_n;
    assign w_wd  = writedata[WIDTH-1:0];
    assign w_ev  = (w_f & ~r_f_d & r_rise_en) | (~w_f & r_f_d & r_fall_en);
    assign w_clr = (w_wr && (address == ADDR_CAPTURE)) ? w_wd : '0;
    assign irq   = |(r_edge_cap & r_irq_mask);

`ifdef MOTOR_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_f;

    // Per-bit stability filter: f follows s2 only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_f <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_f[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_f[i]   <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_f = r_f;
`else
    assign w_f = r_s2;
`endif

    // Next output-register value from DATA load, OUT_SET or OUT_CLR writes.
    always_comb begin
        w_out_nxt = out_port;
        if (w_wr) begin
            case (address)
                ADDR_DATA:    w_out_nxt = w_wd;
                ADDR_OUT_SET: w_out_nxt = out_port | w_wd;
                ADDR_OUT_CLR: w_out_nxt = out_port & ~w_wd;
                default:      w_out_nxt = out_port;
            endcase
        end else begin
            w_out_nxt = out_port;
        end
    end

    // Read mux; unused upper bits and write-only/reserved addresses read as zero.
    always_comb begin
        w_rd = 32'h0000_0000;
        case (address)
            ADDR_DATA:    w_rd[WIDTH-1:0] = w_f;
            ADDR_RISE_EN: w_rd[WIDTH-1:0] = r_rise_en;
            ADDR_MASK:    w_rd[WIDTH-1:0] = r_irq_mask;
            ADDR_CAPTURE: w_rd[WIDTH-1:0] = r_edge_cap;
            ADDR_FALL_EN: w_rd[WIDTH-1:0] = r_fall_en;
            default:      w_rd = 32'h0000_0000;
        endcase
    end

    // Sync chain, control registers, edge capture (event beats a same-cycle clear) and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_f_d      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            out_port   <= RESET_OUT;
            readdata   <= 32'h0000_0000;
        end else begin
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_f_d      <= w_f;
            if (w_wr && (address == ADDR_RISE_EN)) begin
                r_rise_en <= w_wd;
            end
            if (w_wr && (address == ADDR_FALL_EN)) begin
                r_fall_en <= w_wd;
            end
            if (w_wr && (address == ADDR_MASK)) begin
                r_irq_mask <= w_wd;
            end
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_ev;
            out_port   <= w_out_nxt;
            readdata   <= w_rd;
        end
    end

endmodule

// File: tb/tb_motor_pio_edge_ctl.sv
// Directed bench for motor_pio_edge_ctl: a vector table for register access and basic capture,
// followed by hand-written sequences for W1C races, masking, latency, glitches and mid-run reset.
module tb_motor_pio_edge_ctl;

    localparam logic [7:0] RST_OUT = 8'h5A;
`ifdef MOTOR_PIO_DEBOUNCE_EN
    localparam int EXTRA = 16;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [31:0] readdata;
    logic        irq;

    int nvec = 0;
    int nerr = 0;

    motor_pio_edge_ctl #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (16),
        .RESET_OUT       (RST_OUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .out_port   (out_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  inp;
        logic [31:0] rd;
        logic [7:0]  out;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] a, logic cs, logic wn, logic [31:0] wd,
                                logic [7:0] inp, logic [31:0] rd, logic [7:0] out, logic iq);
        vec_t v;
        v.addr = a; v.cs = cs; v.wn = wn; v.wd = wd;
        v.inp = inp; v.rd = rd; v.out = out; v.irq = iq;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic rd_chk(logic [2:0] a, logic [31:0] exp, string nm);
        address = a;
        cyc();
        chk(nm, readdata, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reads of every address after reset.
        for (int a = 0; a < 8; a++) tbl.push_back(mk(3'(a), 1'b0, 1'b1, 32'h0, 8'h00, 32'h0, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd3, 1'b1, 1'b1, 32'h0, 8'h00, 32'h0, RST_OUT, 1'b0));
        // Rising capture on bit0, no capture on its fall, then W1C.
        tbl.push_back(mk(3'd1, 1'b1, 1'b0, 32'h0000_0001, 8'h00, 32'h0, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd2, 1'b1, 1'b0, 32'h0000_0101, 8'h00, 32'h0, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd1, 1'b0, 1'b1, 32'h0, 8'h00, 32'h1, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd2, 1'b0, 1'b1, 32'h0, 8'h00, 32'h1, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd3, 1'b0, 1'b1, 32'h0, 8'h01, 32'h0, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd3, 1'b0, 1'b1, 32'h0, 8'h01, 32'h0, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd3, 1'b0, 1'b1, 32'h0, 8'h01, 32'h0, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd3, 1'b0, 1'b1, 32'h0, 8'h01, 32'h1, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd0, 1'b0, 1'b1, 32'h0, 8'h01, 32'h1, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd0, 1'b0, 1'b1, 32'h0, 8'h00, 32'h1, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd0, 1'b0, 1'b1, 32'h0, 8'h00, 32'h1, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd0, 1'b0, 1'b1, 32'h0, 8'h00, 32'h0, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd3, 1'b0, 1'b1, 32'h0, 8'h00, 32'h1, RST_OUT, 1'b1));
        tbl.push_back(mk(3'd3, 1'b1, 1'b0, 32'h0000_0001, 8'h00, 32'h1, RST_OUT, 1'b0));
        tbl.push_back(mk(3'd3, 1'b0, 1'b1, 32'h0, 8'h00, 32'h0, RST_OUT, 1'b0));
        // Output register load / set / clear and ignored writes.
        tbl.push_back(mk(3'd0, 1'b1, 1'b0, 32'h0000_00A5, 8'h00, 32'h0, 8'hA5, 1'b0));
        tbl.push_back(mk(3'd5, 1'b1, 1'b0, 32'h0000_000A, 8'h00, 32'h0, 8'hAF, 1'b0));
        tbl.push_back(mk(3'd6, 1'b1, 1'b0, 32'h0000_0081, 8'h00, 32'h0, 8'h2E, 1'b0));
        tbl.push_back(mk(3'd0, 1'b0, 1'b0, 32'h0000_00FF, 8'h00, 32'h0, 8'h2E, 1'b0));
        tbl.push_back(mk(3'd0, 1'b1, 1'b1, 32'h0000_00FF, 8'h00, 32'h0, 8'h2E, 1'b0));
        tbl.push_back(mk(3'd5, 1'b1, 1'b1, 32'h0, 8'h00, 32'h0, 8'h2E, 1'b0));
        tbl.push_back(mk(3'd6, 1'b0, 1'b1, 32'h0, 8'h00, 32'h0, 8'h2E, 1'b0));
        tbl.push_back(mk(3'd7, 1'b1, 1'b0, 32'h0000_00FF, 8'h00, 32'h0, 8'h2E, 1'b0));
        tbl.push_back(mk(3'd1, 1'b0, 1'b1, 32'h0, 8'h00, 32'h1, 8'h2E, 1'b0));

        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 8'h00;
        repeat (3) cyc();
        chk("reset_out_port", {24'h0, out_port}, {24'h0, RST_OUT});
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            address = tbl[i].addr; chipselect = tbl[i].cs; write_n = tbl[i].wn;
            writedata = tbl[i].wd; in_port = tbl[i].inp;
            cyc();
            nvec++;
            if (readdata !== tbl[i].rd || out_port !== tbl[i].out || irq !== tbl[i].irq) begin
                nerr++;
                $display("FAIL vec%0d: rd=%h out=%h irq=%b expected rd=%h out=%h irq=%b",
                         i, readdata, out_port, irq, tbl[i].rd, tbl[i].out, tbl[i].irq);
            end
        end
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;

        // Any-edge on bit1 with W1C between edges, then same-cycle event versus clear.
        wr(3'd4, 32'h2);
        wr(3'd1, 32'h2);
        in_port = 8'h02;
        repeat (3 + EXTRA) cyc();
        rd_chk(3'd3, 32'h2, "cap_bit1_rise");
        chk("irq_unmasked_bit1", {31'h0, irq}, 32'h0);
        wr(3'd3, 32'h2);
        rd_chk(3'd3, 32'h0, "cap_bit1_w1c");
        in_port = 8'h00;
        repeat (3 + EXTRA) cyc();
        rd_chk(3'd3, 32'h2, "cap_bit1_fall");
        in_port = 8'h02;
        repeat (2 + EXTRA) cyc();
        wr(3'd3, 32'h2);
        rd_chk(3'd3, 32'h2, "cap_event_beats_w1c");
        wr(3'd2, 32'h2);
        chk("irq_mask_on", {31'h0, irq}, 32'h1);
        wr(3'd2, 32'h0);
        chk("irq_mask_off", {31'h0, irq}, 32'h0);
        rd_chk(3'd3, 32'h2, "cap_kept_when_masked");
        wr(3'd3, 32'h2);
        rd_chk(3'd3, 32'h0, "cap_bit1_cleared");

        // Latency of a rising input to DATA, and a 10-cycle glitch.
        in_port = 8'h00;
        repeat (25) cyc();
        wr(3'd1, 32'h4);
        wr(3'd3, 32'hFF);
        address = 3'd0;
        in_port = 8'h04;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (readdata[2] === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("data_latency", n, 3 + EXTRA);
        in_port = 8'h00;
        repeat (25) cyc();
        wr(3'd3, 32'hFF);
        rd_chk(3'd3, 32'h0, "cap_clear_before_glitch");
        in_port = 8'h04;
        repeat (10) cyc();
        in_port = 8'h00;
        repeat (30) cyc();
`ifdef MOTOR_PIO_DEBOUNCE_EN
        rd_chk(3'd3, 32'h0, "glitch_filtered");
`else
        rd_chk(3'd3, 32'h4, "glitch_captured");
`endif

        // Reset with everything captured and outputs driven; input held high through reset.
        in_port = 8'hFF;
        wr(3'd1, 32'hFF);
        repeat (2 + EXTRA) cyc();
        wr(3'd0, 32'h3C);
        wr(3'd2, 32'hFF);
        chk("irq_all_captured", {31'h0, irq}, 32'h1);
        chk("out_before_reset", {24'h0, out_port}, 32'h3C);
        rd_chk(3'd3, 32'hFF, "cap_all_set");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_mid_out", {24'h0, out_port}, {24'h0, RST_OUT});
        chk("rst_mid_irq", {31'h0, irq}, 32'h0);
        chk("rst_mid_readdata", readdata, 32'h0);
        wr(3'd1, 32'h10);
        chk("rst_mid_rise_en", readdata, 32'h0);
        rd_chk(3'd2, 32'h0, "rst_mid_irq_mask");
        repeat (EXTRA) cyc();
        rd_chk(3'd3, 32'h0, "rst_mid_cap");
        rd_chk(3'd3, 32'h10, "rise_after_reset_release");
        rd_chk(3'd4, 32'h0, "rst_mid_fall_en");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/motor_pio_edge_ctl.md
Name: motor_pio_edge_ctl

Overview:
Parametrised Avalon-MM slave PIO for the stepper-motor subsystem, successor to the fixed 4-bit any-edge input PIO.
- Provides WIDTH synchronised inputs with per-bit rising/falling edge selection and write-1-to-clear edge capture.
- Adds a WIDTH-bit output register with atomic set/clear, and an interrupt output.
- Sits on the HPS/Nios lightweight bus beside the motor driver; inputs are limit switches and encoder index lines, outputs are driver enables.

Parameters:
WIDTH, 8, number of input bits and output bits; legal range 1..32.
DEBOUNCE_CYCLES, 16, stable-cycle count for the filter; legal range 2..65535; used only with MOTOR_PIO_DEBOUNCE_EN.
RESET_OUT, 0, reset value of out_port, WIDTH bits.

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
address  in  3  word address of the register.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
writedata  in  32  write data; bits above WIDTH are ignored.
in_port  in  WIDTH  asynchronous external inputs.
out_port  out  WIDTH  output register.
readdata  out  32  registered read data; bits above WIDTH read 0.
irq  out  1  level interrupt, equal to OR(edge_capture & irq_mask).

Behaviour:
- Reset (sync, clk edge with reset=1): sync stages, filtered value f, f_d, irq_mask, rise_en, fall_en, edge_capture and readdata go to 0. out_port goes to RESET_OUT. irq goes to 0.
- Sync chain: s1<=in_port, s2<=s1. Without the filter, f=s2. f_d<=f every cycle.
- Edge detect: rise=f&~f_d&rise_en; fall=~f&f_d&fall_en; ev=rise|fall.
- Setting both rise_en and fall_en on a bit gives any-edge behaviour.
- An input held high through reset produces a rising event after release if enabled; this is required behaviour.
- Latency: an in_port change first sampled at edge k appears in DATA readdata and sets edge_capture/irq after edge k+2, with address held.
- Register map (R/W):
  - 0 DATA: read f; write loads out_port.
  - 1 RISE_EN: rise_en, R/W.
  - 2 IRQ_MASK: irq_mask, R/W.
  - 3 EDGE_CAPTURE: read; writing a 1 clears that bit (write-1-to-clear), writing a 0 leaves it unchanged.
  - 4 FALL_EN: fall_en, R/W.
  - 5 OUT_SET: out_port |= wd; reads 0.
  - 6 OUT_CLR: out_port &= ~wd; reads 0.
  - 7 reserved: reads 0, writes ignored.
- readdata: registered every clock from the current address, independent of chipselect; read latency is 1 cycle.
- Capture update per bit: edge_capture <= (edge_capture & ~clr) | ev.
- If an event and a W1C clear hit the same bit in the same cycle, the event wins and the bit stays 1.
- irq is combinational from registers, with no extra cycle. Masking an already-set capture deasserts irq without clearing the capture.
- Writes to unused bits have no effect. Back-to-back writes on consecutive cycles are all honoured.
- Reset asserted mid-debounce or mid-capture discards all state; the first cycle after reset behaves as a fresh start.

Optional Feature:
MOTOR_PIO_DEBOUNCE_EN:
- Defined: each bit has a counter of clog2(DEBOUNCE_CYCLES+1) bits.
  - Counter clears whenever s2==f.
  - Counter increments while s2!=f.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s2 still different, f<=s2 and the counter clears.
  - Net effect: f changes only after s2 holds a new value for DEBOUNCE_CYCLES consecutive cycles. Added latency is exactly DEBOUNCE_CYCLES cycles.
  - Glitches shorter than that never reach f or edge_capture.
- Undefined: no counters; f=s2 combinationally and latency is as stated above.

Test Plan:
1. Reset, then read all 8 addresses -> out_port=RESET_OUT, every readdata=0, irq=0.
2. WIDTH=8, write RISE_EN=0x01, IRQ_MASK=0x01, drive in_port[0] 0->1 -> EDGE_CAPTURE=0x01 and irq=1 after edge k+2. Then drive 1->0 -> no new capture. Write 0x01 to addr 3 -> capture=0, irq=0.
3. Write FALL_EN=0x02 and RISE_EN=0x02, toggle bit1 high then low with a W1C of 0x02 issued between the two edges -> capture set, cleared, set again. Same-cycle event plus W1C on bit1 -> bit stays 1.
4. Write DATA=0xA5, OUT_SET=0x0A, OUT_CLR=0x81 -> out_port sequence 0xA5, 0xAF, 0x2E. Reads of addresses 5 and 6 return 0.
5. With MOTOR_PIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16, pulse in_port[2] high for 10 cycles -> DATA bit2 stays 0 and no capture. Hold it high for 20 cycles -> bit2=1 exactly 16 cycles later than in the no-debounce build.
6. Assert reset for 1 cycle while capture=0xFF and out_port=0x3C -> next cycle capture=0, out_port=RESET_OUT, irq=0, and irq_mask reads 0.
